fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter A, default 4, instruction address width.
REQ-002 Parameter W, default 9, instruction word width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 inst_addr_in  input  A  fetch address from the PC stage, valid every cycle.
REQ-007 halt  output  1  to PC stage; 1 = hold address, do not advance.
REQ-008 flush  input  1  taken branch this cycle (ctrl_branch && take_branch at PC stage).
REQ-009 mem_addr  output  A  address to synchronous instruction ROM.
REQ-010 mem_data  input  W  ROM read data, one cycle after mem_addr.
REQ-011 out_valid  output  1  head entry valid to decode.
REQ-012 out_inst  output  W  head instruction.
REQ-013 out_addr  output  A  head instruction address.
REQ-014 out_ready  input  1  decode accepts head this cycle.

Function
REQ-015 mem_addr SHALL equal inst_addr_in combinationally.
REQ-016 Issue: a cycle with halt=0, flush=0, reset=1 SHALL issue inst_addr_in; pending<=1, pend_addr<=inst_addr_in; otherwise pending<=0.
REQ-017 Push: a cycle with pending=1 and flush=0 SHALL write {mem_data, pend_addr} at write pointer; wptr increments mod DEPTH.
REQ-018 Pop: out_valid && out_ready SHALL advance rptr mod DEPTH.
REQ-019 Count SHALL update: +1 push only, -1 pop only, unchanged on push+pop, range 0..DEPTH.
REQ-020 out_valid SHALL be (count != 0); out_inst/out_addr SHALL be the entry at rptr, from registers.
REQ-021 Latency: address issued in cycle t SHALL appear at the head no earlier than t+2, when queue empty exactly t+2.
REQ-022 halt SHALL be combinational: !flush && (count + pending >= DEPTH); reserves a slot for every in-flight fetch.
REQ-023 halt SHALL be 0 whenever flush=1, so the PC stage loads the branch target.
REQ-024 Overflow SHALL be impossible: push never occurs with count=DEPTH and no pop.
REQ-025 Flush SHALL, at that posedge: count<=0, rptr<=0, wptr<=0, pending<=0; ROM data returning next cycle SHALL be discarded.
REQ-026 Flush with pop in same cycle: pop acknowledged, queue empty after edge.
REQ-027 Flush with push in same cycle: push dropped.
REQ-028 Pop with out_valid=0 SHALL have no effect.
REQ-029 Push and pop at count=DEPTH-1 or DEPTH SHALL leave count unchanged and order preserved.
REQ-030 Pointer wrap SHALL be modulo DEPTH with no lost or duplicated entries.

Reset
REQ-031 reset=0 SHALL asynchronously clear count, rptr, wptr, pending, pend_addr and all entries to 0.
REQ-032 During and after reset: out_valid=0, out_inst=0, out_addr=0, halt=0.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight fetches; first issue in the first cycle with reset=1.
REQ-034 Reset released asynchronously SHALL not cause push in that cycle (pending=0).

Verification
REQ-035 Reset, then ROM[a]=a+0x100, out_ready=1, addr 0,1,2 on cycles 0,1,2 -> out_valid from cycle 2; out_addr 0,1,2, out_inst 0x100,0x101,0x102 on cycles 2,3,4.
REQ-036 out_ready=0, addresses stream -> halt=1 once count+pending=4; exactly 4 entries (addr 0..3), held address 4 not lost; out_ready=1 then yields 4 next after 3.
REQ-037 Queue full, halt=1, flush=1 -> halt=0 in that cycle; next cycle out_valid=0, count=0; returning ROM data dropped; first new entry is branch target.
REQ-038 count=3, pending=1, out_ready=1 continuous -> simultaneous push/pop; count stays 3; ordering intact across rptr/wptr wrap 3->0.
REQ-039 reset=0 asserted mid-cycle with count=2, pending=1 -> out_valid and halt fall to 0 without clock edge; no stale entry after release.
REQ-040 flush with out_valid=1, out_ready=1 -> head popped once, queue empty, no duplicate or stale output.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: PC-stage address/halt/flush, instruction ROM port and decode-side handshake.
// The queue itself takes the slave modport; the environment drives it through master.
interface fetch_queue_if #(
   parameter int unsigned A = 4,
   parameter int unsigned W = 9
) ();
   logic [A-1:0] inst_addr_in;
   logic         halt;
   logic         flush;
   logic [A-1:0] mem_addr;
   logic [W-1:0] mem_data;
   logic         out_valid;
   logic [W-1:0] out_inst;
   logic [A-1:0] out_addr;
   logic         out_ready;

   modport master (
      output inst_addr_in, flush, mem_data, out_ready,
      input  halt, mem_addr, out_valid, out_inst, out_addr
   );

   modport slave (
      input  inst_addr_in, flush, mem_data, out_ready,
      output halt, mem_addr, out_valid, out_inst, out_addr
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC addresses to a synchronous ROM and buffers the returned
// words in a DEPTH-entry FIFO; halt reserves a slot for every fetch still in flight.
module fetch_queue #(
   parameter int unsigned A     = 4,
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic          pending_q, pending_d;
   logic [A-1:0]  pend_addr_q, pend_addr_d;
   logic [W-1:0]  inst_q [DEPTH];
   logic [A-1:0]  addr_q [DEPTH];

   logic [OW-1:0] occupancy;
   logic          issue;
   logic          push;
   logic          pop;

   assign bus.mem_addr = bus.inst_addr_in;

   // Entries already queued plus the one fetch whose ROM data is still on its way.
   assign occupancy = {1'b0, count_q} + OW'(pending_q);
   assign bus.halt  = !bus.flush && (occupancy >= OW'(DEPTH));

   assign issue = !bus.halt && !bus.flush;
   assign push  = pending_q && !bus.flush;
   assign pop   = bus.out_valid && bus.out_ready;

   assign bus.out_valid = (count_q != '0);
   assign bus.out_inst  = inst_q[rptr_q];
   assign bus.out_addr  = addr_q[rptr_q];

   always_comb begin
      count_d     = count_q;
      rptr_d      = rptr_q;
      wptr_d      = wptr_q;
      pending_d   = issue;
      pend_addr_d = issue ? bus.inst_addr_in : pend_addr_q;

      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      // A taken branch empties the queue and drops any data returning from the ROM.
      if (bus.flush) begin
         count_d   = '0;
         rptr_d    = '0;
         wptr_d    = '0;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         rptr_q      <= '0;
         wptr_q      <= '0;
         pending_q   <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         count_q     <= count_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         pending_q   <= pending_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else if (push) begin
         inst_q[wptr_q] <= bus.mem_data;
         addr_q[wptr_q] <= pend_addr_q;
      end
   end
endmodule
